// File: rtl/key_expansion_seq.sv
// AES key schedule generator for 128/192/256-bit keys.
// The core emits one schedule word per cycle from a sliding window of the last
// nk words and keeps every word in a 60-entry store, so any round key can be
// read back combinationally once the schedule is complete.
module key_expansion_seq #(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  output logic [31:0]  rk_word,
  output logic [5:0]   rk_idx,
  output logic         done,
  output logic         err,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         key_ready
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  state_t      state;
  logic [31:0] win [8];
  logic [31:0] store [60];
  logic [7:0]  rcon;
  logic [5:0]  cnt;
  logic [2:0]  pos;
  logic [2:0]  nkm1;
  logic [3:0]  nr;
  logic [5:0]  last_idx;

  logic        start_ok;
  logic [31:0] prev;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t;
  logic [31:0] new_word;
  logic        emit_en;
  logic [31:0] emit_word;
  logic [5:0]  emit_idx;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      2'd0:    return 4'd4;
      2'd1:    return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign start_ok = (key_len != 2'd3) && ({28'd0, nk_of(key_len)} <= MAX_NK);
  assign sub_out  = sub_word(sub_in);
  assign new_word = win[0] ^ t;

  // Select the recurrence term t from w[i-1] according to i mod nk.
  always_comb begin
    prev   = win[nkm1];
    sub_in = (pos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    t      = prev;
    if (pos == 3'd0)
      t = sub_out ^ {rcon, 24'h0};
    else if (nkm1 == 3'd7 && pos == 3'd4)
      t = sub_out;
  end

  // Word to emit this cycle: w0 on acceptance, key words in LOAD, computed words in EXPAND.
  always_comb begin
    emit_en   = 1'b0;
    emit_word = 32'h0;
    emit_idx  = 6'd0;
    case (state)
      IDLE: begin
        if (start && start_ok) begin
          emit_en   = 1'b1;
          emit_word = key[255:224];
        end
      end
      LOAD: begin
        emit_en   = 1'b1;
        emit_word = win[cnt[2:0]];
        emit_idx  = cnt;
      end
      EXPAND: begin
        if (!done) begin
          emit_en   = 1'b1;
          emit_word = new_word;
          emit_idx  = cnt;
        end
      end
      default: ;
    endcase
  end

  // Schedule store; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (rst_n && emit_en) store[emit_idx] <= emit_word;
  end

  // Control FSM, output registers, window and rcon update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      key_ready <= 1'b0;
      rk_word   <= 32'h0;
      rk_idx    <= 6'd0;
      rcon      <= 8'h01;
      cnt       <= 6'd0;
      pos       <= 3'd0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= emit_en;
      if (emit_en) begin
        rk_word <= emit_word;
        rk_idx  <= emit_idx;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              state     <= LOAD;
              busy      <= 1'b1;
              key_ready <= 1'b0;
              rcon      <= 8'h01;
              cnt       <= 6'd1;
              for (int j = 0; j < 8; j++) win[j] <= key[255 - 32*j -: 32];
              case (key_len)
                2'd0:    begin nkm1 <= 3'd3; nr <= 4'd10; last_idx <= 6'd43; end
                2'd1:    begin nkm1 <= 3'd5; nr <= 4'd12; last_idx <= 6'd51; end
                default: begin nkm1 <= 3'd7; nr <= 4'd14; last_idx <= 6'd59; end
              endcase
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          cnt <= cnt + 6'd1;
          if (cnt[2:0] == nkm1) begin
            state <= EXPAND;
            pos   <= 3'd0;
          end
        end
        EXPAND: begin
          if (done) begin
            state     <= IDLE;
            busy      <= 1'b0;
            key_ready <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
            pos <= (pos == nkm1) ? 3'd0 : pos + 3'd1;
            if (pos == 3'd0) rcon <= xtime(rcon);
            for (int j = 0; j < 7; j++) begin
              if (j < int'(nkm1)) win[j] <= win[j+1];
            end
            win[nkm1] <= new_word;
            if (cnt == last_idx) done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Round-key read port, gated by completion and round range.
  always_comb begin
    rd_key = 128'h0;
    if (key_ready && rd_round <= nr)
      rd_key = {store[{rd_round, 2'b00}], store[{rd_round, 2'b01}],
                store[{rd_round, 2'b10}], store[{rd_round, 2'b11}]};
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Testbench for key_expansion_seq: table-driven reference schedule feeding a
// scoreboard queue, plus directed checks of the published AES vectors.
module tb_key_expansion_seq;

  logic         clk = 1'b0;
  logic         rst_n, start, start4;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [3:0]   rd_round;
  logic         busy, rk_valid, done, err, key_ready;
  logic [31:0]  rk_word;
  logic [5:0]   rk_idx;
  logic [127:0] rd_key;
  logic         busy4, rk_valid4, done4, err4, key_ready4;
  logic [31:0]  rk_word4;
  logic [5:0]   rk_idx4;
  logic [127:0] rd_key4;

  always #5 clk = ~clk;

  key_expansion_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .rk_valid(rk_valid), .rk_word(rk_word), .rk_idx(rk_idx),
    .done(done), .err(err), .rd_round(rd_round), .rd_key(rd_key), .key_ready(key_ready)
  );

  key_expansion_seq #(.MAX_NK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key_len(key_len), .key(key),
    .busy(busy4), .rk_valid(rk_valid4), .rk_word(rk_word4), .rk_idx(rk_idx4),
    .done(done4), .err(err4), .rd_round(rd_round), .rd_key(rd_key4), .key_ready(key_ready4)
  );

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_cafef00d};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffff_ffffffff};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] w;
  } item_t;

  item_t       sb [$];
  logic [31:0] mw [60];
  logic [31:0] obs_w [64];
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  function automatic logic [7:0] tsbox(input logic [7:0] b);
    return SBOX_T[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] tsub(input logic [31:0] w);
    return {tsbox(w[31:24]), tsbox(w[23:16]), tsbox(w[15:8]), tsbox(w[7:0])};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond);
    checks++;
    assert (cond) else begin
      errors++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  // Reference schedule (FIPS-197 recurrence with a table S-box); pushes every word.
  task automatic model_push(input logic [255:0] k, input logic [1:0] kl);
    int          nk, tot;
    logic [31:0] tmp;
    logic [7:0]  rc;
    nk  = 4 + 2 * int'(kl);
    tot = 4 * (nk + 7);
    rc  = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < tot; i++) begin
      tmp = mw[i-1];
      if (i % nk == 0) begin
        tmp = tsub({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = tsub(tmp);
      end
      mw[i] = mw[i-nk] ^ tmp;
    end
    for (int i = 0; i < tot; i++) sb.push_back({6'(i), mw[i]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First tick is the edge that accepts start; runs until done or a bound expires.
  task automatic collect(input int total, input bit hold, input int poke_at,
                         input int rst_at, output int ncyc);
    bit    done_seen;
    int    err_seen;
    item_t e;
    ncyc      = 0;
    done_seen = 0;
    err_seen  = 0;
    for (int n = 0; n < 100 && !done_seen; n++) begin
      tick();
      ncyc++;
      if (ncyc == 1) begin
        if (!hold) start = 1'b0;
        chk("accept_busy", busy, 1'b1);
        chk("accept_key_ready", key_ready, 1'b0);
      end
      if (err) err_seen++;
      if (poke_at == ncyc) begin
        start   = 1'b1;
        key_len = 2'd3;
        key     = '1;
      end else if (poke_at > 0 && ncyc == poke_at + 1) begin
        start = 1'b0;
      end
      if (rk_valid) begin
        if (sb.size() == 0) begin
          chk_true("sb_underflow", 1'b0);
        end else begin
          e = sb.pop_front();
          chk("word", {rk_idx, rk_word}, {e.idx, e.w});
          obs_w[rk_idx] = rk_word;
        end
      end
      if (rst_at >= 0 && rk_valid && rk_idx == 6'(rst_at)) begin
        rst_n = 1'b0;
        tick();
        chk("rst_mid_valid", rk_valid, 1'b0);
        chk("rst_mid_key_ready", key_ready, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        return;
      end
      if (done) done_seen = 1;
    end
    chk_true("done_seen", done_seen);
    chk("latency", ncyc, total);
    chk("no_err_while_busy", err_seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; key_len = 2'd0; key = '0; rd_round = 4'd0;
    tick();
    tick();
    chk("reset_ctrl", {busy, rk_valid, done, err, key_ready}, 5'b0);
    chk("reset_word", {rk_idx, rk_word}, 38'h0);
    chk("reset_rd_key", rd_key, 128'h0);
    rst_n = 1'b1;
    tick();

    // Illegal key_len
    key_len = 2'd3; start = 1'b1;
    tick();
    chk("illegal_err", err, 1'b1);
    chk("illegal_busy", busy, 1'b0);
    start = 1'b0;
    tick();
    chk("illegal_err_pulse", err, 1'b0);
    chk("illegal_busy_after", busy, 1'b0);

    // nk larger than MAX_NK on the small instance
    key_len = 2'd2; start4 = 1'b1;
    tick();
    chk("maxnk_err_256", err4, 1'b1);
    chk("maxnk_busy_256", busy4, 1'b0);
    key_len = 2'd1;
    tick();
    chk("maxnk_err_192", err4, 1'b1);
    key_len = 2'd0;
    tick();
    chk("maxnk_ok_128_err", err4, 1'b0);
    chk("maxnk_ok_128_busy", busy4, 1'b1);
    start4 = 1'b0;

    // AES-128 (low key bits carry junk that must be ignored)
    key = K128; key_len = 2'd0;
    model_push(key, key_len);
    start = 1'b1;
    collect(44, 1'b0, -1, -1, cyc);
    chk("aes128_w4", obs_w[4], 32'ha0fafe17);
    chk("aes128_w43", obs_w[43], 32'hb6630ca6);
    tick();
    chk("aes128_key_ready", {key_ready, busy, rk_valid}, 3'b100);
    chk("aes128_hold", {rk_idx, rk_word}, {6'd43, 32'hb6630ca6});
    rd_round = 4'd10; #1;
    chk("aes128_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_round = 4'd11; #1;
    chk("aes128_rd11_zero", rd_key, 128'h0);
    rd_round = 4'd0; #1;
    chk("aes128_rd0", rd_key, K128[255:128]);

    // AES-192
    key = K192; key_len = 2'd1;
    model_push(key, key_len);
    start = 1'b1;
    collect(52, 1'b0, -1, -1, cyc);
    chk("aes192_w6", obs_w[6], 32'hfe0c91f7);
    chk("aes192_w51", obs_w[51], 32'h01002202);
    tick();
    rd_round = 4'd12; #1;
    chk("aes192_rd12", rd_key, {mw[48], mw[49], mw[50], mw[51]});
    rd_round = 4'd13; #1;
    chk("aes192_rd13_zero", rd_key, 128'h0);

    // AES-256 with an illegal start poked in mid-run
    key = K256; key_len = 2'd2;
    model_push(key, key_len);
    start = 1'b1;
    collect(60, 1'b0, 20, -1, cyc);
    chk("aes256_w8", obs_w[8], 32'h9ba35411);
    chk("aes256_w12", obs_w[12], 32'ha8b09c1a);
    chk("aes256_w59", obs_w[59], 32'h706c631e);
    tick();
    chk("aes256_err_after", err, 1'b0);
    rd_round = 4'd14; #1;
    chk("aes256_rd14", rd_key, {mw[56], mw[57], mw[58], mw[59]});
    rd_round = 4'd0; #1;
    chk("aes256_rd0", rd_key, K256[255:128]);
    rd_round = 4'd15; #1;
    chk("aes256_rd15_zero", rd_key, 128'h0);

    // Reset at word 20, then a start on the first cycle out of reset
    key = K128; key_len = 2'd0;
    model_push(key, key_len);
    start = 1'b1;
    collect(44, 1'b0, -1, 20, cyc);
    sb.delete();
    rst_n = 1'b1;
    model_push(key, key_len);
    start = 1'b1;
    collect(44, 1'b0, -1, -1, cyc);
    chk("rerun_w43", obs_w[43], 32'hb6630ca6);
    tick();
    rd_round = 4'd10; #1;
    chk("rerun_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Back-to-back with start held high
    model_push(key, key_len);
    model_push(key, key_len);
    start = 1'b1;
    collect(44, 1'b1, -1, -1, cyc);
    tick();
    chk("b2b_idle_cycle", {rk_valid, busy, key_ready}, 3'b001);
    collect(44, 1'b0, -1, -1, cyc);
    chk("sb_drained", sb.size(), 0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
